// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator.
// Holds the default counter widths and the FSM state type.
package spi_pkg;

  localparam int unsigned SPI_DIV_W = 8;
  localparam int unsigned SPI_CNT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sclk_state_t;

endpackage : spi_pkg

// File: rtl/div_counter.sv
// Half-period divide counter for the SCLK generator.
// Ports:
//   clk_in   - system clock
//   reset    - synchronous active-high reset
//   i_clear  - force count to zero
//   i_en     - count enable
//   i_max    - terminal value; count returns to zero after reaching it
//   o_tc_c   - combinational terminal-count flag (enabled and count == i_max)
module div_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_max,
  output logic             o_tc_c
);

  logic [WIDTH-1:0] r_count;

  assign o_tc_c = i_en && (r_count == i_max);

  // Wraps at i_max, so the count never passes the latched terminal value.
  always_ff @(posedge clk_in) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc_c ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule : div_counter

// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: emits bursts of num_bits SCLK cycles with a
// programmable half-period, plus lead/trail edge strobes for the shifter.
// Ports:
//   clk_in, reset          - system clock, synchronous active-high reset
//   div_half               - half-period in clk_in cycles minus 1
//   cpol                   - SCLK idle level
//   num_bits               - SCLK cycles per burst (0 = immediate done)
//   start                  - burst request, sampled only in IDLE
//   sclk                   - generated serial clock
//   lead_edge / trail_edge - strobes coincident with SCLK leaving / returning to idle
//   busy                   - burst in progress
//   done                   - one-cycle strobe at burst completion
module spi_sclk_gen #(
  parameter int unsigned DIV_W = spi_pkg::SPI_DIV_W,
  parameter int unsigned CNT_W = spi_pkg::SPI_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_half,
  input  logic             cpol,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             start,
  output logic             sclk,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             busy,
  output logic             done
);

  import spi_pkg::*;

  sclk_state_t      r_state;
  logic [DIV_W-1:0] r_div_half;
  logic             r_cpol;
  logic [CNT_W-1:0] r_num_bits;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_sclk;
  logic             r_lead;
  logic             r_trail;
  logic             r_busy;
  logic             r_done;
  logic             w_run;
  logic             w_tc;

  assign w_run = (r_state == RUN);

  // Counter is held at zero in IDLE and free-runs against the latched divide in RUN.
  div_counter #(
    .WIDTH (DIV_W)
  ) u_div_counter (
    .clk_in  (clk_in),
    .reset   (reset),
    .i_clear (~w_run),
    .i_en    (w_run),
    .i_max   (r_div_half),
    .o_tc_c  (w_tc)
  );

  // FSM, SCLK toggling, edge strobes and trail-edge bit counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= IDLE;
      r_div_half <= '0;
      r_cpol     <= 1'b0;
      r_num_bits <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= cpol;
      r_lead     <= 1'b0;
      r_trail    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk    <= cpol;
          r_bit_cnt <= '0;
          if (start) begin
            if (num_bits != '0) begin
              r_div_half <= div_half;
              r_cpol     <= cpol;
              r_num_bits <= num_bits;
              r_state    <= RUN;
              r_busy     <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_tc) begin
            r_sclk <= ~r_sclk;
            // Currently at idle level -> this toggle leaves it.
            if (r_sclk == r_cpol) begin
              r_lead <= 1'b1;
            end else begin
              r_trail <= 1'b1;
              if (r_bit_cnt == r_num_bits - CNT_W'(1)) begin
                r_bit_cnt <= '0;
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sclk       = r_sclk;
  assign lead_edge  = r_lead;
  assign trail_edge = r_trail;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule : spi_sclk_gen

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: table of bursts measured against expected timing,
// plus hand sequences for zero-length bursts, mid-burst reset and back-to-back.
module tb_spi_sclk_gen;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 6;

  logic             clk_in = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] div_half;
  logic             cpol;
  logic [CNT_W-1:0] num_bits;
  logic             start;
  logic             sclk;
  logic             lead_edge;
  logic             trail_edge;
  logic             busy;
  logic             done;

  spi_sclk_gen #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .div_half   (div_half),
    .cpol       (cpol),
    .num_bits   (num_bits),
    .start      (start),
    .sclk       (sclk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int dh;
    int cp;
    int nb;
    bit mangle;
    int exp_half;  // expected half period = first toggle delay
    int exp_len;   // expected cycles from busy rise to done
  } vec_t;

  typedef struct {
    int half;
    int len;
    int edges;
    int level;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one burst, measure it, pop the expected record once done appears.
  task automatic run_burst(input vec_t v);
    exp_t e;
    exp_t got;
    int   t, last_tog, first, minh, maxh, leads, trails, bad, busy_drop;
    int   done_t, done_tr, done_busy, done_lvl;
    logic prev;
    e.half  = v.exp_half;
    e.len   = v.exp_len;
    e.edges = v.nb;
    e.level = v.cp;
    sb.push_back(e);
    div_half = DIV_W'(v.dh);
    cpol     = 1'(v.cp);
    num_bits = CNT_W'(v.nb);
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    t = 0; last_tog = 0; first = -1; minh = 1 << 30; maxh = 0;
    leads = 0; trails = 0; bad = 0; busy_drop = 0;
    done_t = -1; done_tr = 0; done_busy = 0; done_lvl = 0;
    prev = sclk;
    while (done_t < 0 && t < v.exp_len + 50) begin
      if (v.mangle && t < v.exp_len - 10) begin
        div_half = DIV_W'(2);
        start    = 1'($urandom_range(0, 1));
        cpol     = 1'($urandom_range(0, 1));
        num_bits = CNT_W'($urandom);
      end else if (v.mangle) begin
        start = 1'b0;
        cpol  = 1'(v.cp);
      end
      tick();
      t++;
      if (sclk != prev) begin
        if (first < 0) first = t;
        else begin
          if (t - last_tog < minh) minh = t - last_tog;
          if (t - last_tog > maxh) maxh = t - last_tog;
        end
        last_tog = t;
        if (lead_edge != (sclk != 1'(v.cp))) bad++;
        if (trail_edge != (sclk == 1'(v.cp))) bad++;
      end else if (lead_edge || trail_edge) begin
        bad++;
      end
      leads  += int'(lead_edge);
      trails += int'(trail_edge);
      if (done) begin
        done_t    = t;
        done_tr   = int'(trail_edge);
        done_busy = int'(busy);
        done_lvl  = int'(sclk);
      end else if (!busy) begin
        busy_drop++;
      end
      prev = sclk;
    end
    start = 1'b0;
    got = sb.pop_front();
    check("done_seen", int'(done_t >= 0), 1);
    check("first_toggle", first, got.half);
    check("half_min", minh, got.half);
    check("half_max", maxh, got.half);
    check("lead_count", leads, got.edges);
    check("trail_count", trails, got.edges);
    check("strobe_align", bad, 0);
    check("done_time", done_t, got.len);
    check("done_with_trail", done_tr, 1);
    check("busy_at_done", done_busy, 0);
    check("busy_gap", busy_drop, 0);
    check("final_sclk", done_lvl, got.level);
  endtask

  vec_t tbl[7];

  initial begin
    int   t, leads, cnt, d1;
    vec_t v;
    reset = 1'b1; div_half = '0; cpol = 1'b0; num_bits = '0; start = 1'b0;

    tbl[0] = '{dh: 9,   cp: 0, nb: 8,  mangle: 1'b0, exp_half: 10,  exp_len: 160};
    tbl[1] = '{dh: 0,   cp: 1, nb: 3,  mangle: 1'b0, exp_half: 1,   exp_len: 6};
    tbl[2] = '{dh: 9,   cp: 0, nb: 8,  mangle: 1'b1, exp_half: 10,  exp_len: 160};
    tbl[3] = '{dh: 3,   cp: 1, nb: 5,  mangle: 1'b0, exp_half: 4,   exp_len: 40};
    tbl[4] = '{dh: 1,   cp: 0, nb: 1,  mangle: 1'b0, exp_half: 2,   exp_len: 4};
    tbl[5] = '{dh: 0,   cp: 0, nb: 63, mangle: 1'b0, exp_half: 1,   exp_len: 126};
    tbl[6] = '{dh: 255, cp: 1, nb: 1,  mangle: 1'b0, exp_half: 256, exp_len: 512};

    // Reset state; sclk follows cpol while reset is held.
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_strobes", int'(lead_edge) + int'(trail_edge), 0);
    check("rst_sclk0", int'(sclk), 0);
    cpol = 1'b1;
    tick();
    check("rst_sclk1", int'(sclk), 1);

    // Start accepted on the first cycle out of reset.
    reset = 1'b0; cpol = 1'b0; div_half = '0; num_bits = CNT_W'(1); start = 1'b1;
    tick();
    start = 1'b0;
    check("start_after_rst", int'(busy), 1);
    cnt = 0;
    while (busy && cnt < 20) begin tick(); cnt++; end
    check("short_burst_end", int'(busy), 0);
    tick();

    foreach (tbl[i]) begin
      run_burst(tbl[i]);
      tick();
    end

    // Zero-length burst: done next cycle, no busy, sclk untouched.
    cpol = 1'b1;
    tick(); tick();
    num_bits = '0; div_half = DIV_W'(4); start = 1'b1;
    tick();
    start = 1'b0;
    check("nb0_done", int'(done), 1);
    check("nb0_busy", int'(busy), 0);
    check("nb0_sclk", int'(sclk), 1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cnt += int'(busy) + int'(done) + int'(lead_edge) + int'(trail_edge) + int'(sclk != 1'b1);
    end
    check("nb0_quiet", cnt, 0);

    // Reset after the third lead edge aborts the burst silently.
    cpol = 1'b0; div_half = DIV_W'(2); num_bits = CNT_W'(8); start = 1'b1;
    tick();
    start = 1'b0;
    leads = 0; t = 0;
    while (leads < 3 && t < 100) begin
      tick(); t++;
      leads += int'(lead_edge);
    end
    check("abort_leads_seen", leads, 3);
    reset = 1'b1; cpol = 1'b1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_sclk", int'(sclk), 1);
    check("abort_strobes", int'(lead_edge) + int'(trail_edge), 0);
    check("abort_done", int'(done), 0);
    reset = 1'b0; cpol = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin tick(); cnt += int'(done) + int'(busy); end
    check("abort_no_done", cnt, 0);
    v = '{dh: 2, cp: 0, nb: 8, mangle: 1'b0, exp_half: 3, exp_len: 48};
    run_burst(v);
    tick();

    // Back-to-back: start held high across done.
    div_half = DIV_W'(1); cpol = 1'b0; num_bits = CNT_W'(2); start = 1'b1;
    tick();
    t = 0;
    while (!done && t < 40) begin tick(); t++; end
    check("b2b_first_done_t", t, 8);
    check("b2b_busy_at_done", int'(busy), 0);
    tick();
    start = 1'b0;
    check("b2b_restart", int'(busy), 1);
    t = 0; leads = 0; d1 = 0;
    while (!done && t < 40) begin tick(); t++; leads += int'(lead_edge); end
    check("b2b_second_done_t", t, 8);
    check("b2b_second_leads", leads, 2);
    d1 = int'(done);
    check("b2b_second_done", d1, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spi_sclk_gen

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 Parameter DIV_W, default 8: width of the half-period divide value.
REQ-002 Parameter CNT_W, default 6: width of the SCLK cycle count.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_in  input  1: system clock; all logic on posedge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 div_half  input  DIV_W: SCLK half-period in clk_in cycles minus 1; the value 9 gives 5 MHz from 100 MHz.
REQ-007 cpol  input  1: SCLK idle level.
REQ-008 num_bits  input  CNT_W: number of SCLK cycles per burst.
REQ-009 start  input  1: burst request, sampled only in IDLE.
REQ-010 sclk  output  1: generated serial clock, registered.
REQ-011 lead_edge  output  1: one-cycle strobe on each leaving-idle-level SCLK transition.
REQ-012 trail_edge  output  1: one-cycle strobe on each return-to-idle-level SCLK transition.
REQ-013 busy  output  1: high while a burst is running.
REQ-014 done  output  1: one-cycle strobe when a burst completes.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 In IDLE: sclk = cpol input (tracked every cycle), busy = 0, the divide counter = 0, and lead_edge = trail_edge = 0.
REQ-017 IDLE with start=1 and num_bits != 0: latch div_half, cpol and num_bits, clear the counter, and enter RUN on the next edge (busy = 1).
REQ-018 IDLE with start=1 and num_bits = 0: stay in IDLE, pulse done for exactly one cycle, and produce no SCLK edges.
REQ-019 In RUN the counter SHALL increment each cycle; when it equals the latched div_half, it returns to 0 and sclk toggles.
- Half-period = div_half+1 cycles.
- div_half = 0 gives sclk = clk_in/2.
REQ-020 The first toggle SHALL occur div_half+1 cycles after busy rises.
REQ-021 lead_edge/trail_edge SHALL be high in the same cycle sclk first shows the new level.
- A toggle away from the latched cpol is a lead edge.
- A toggle back to the latched cpol is a trail edge.
REQ-022 A bit counter SHALL count trail edges; on the num_bits-th trail edge:
- state -> IDLE and busy -> 0 in the same cycle.
- done = 1 coincident with that trail_edge.
REQ-023 start, div_half, cpol and num_bits changes during RUN SHALL be ignored; the latched values govern the whole burst.
REQ-024 A start in the same cycle done is high SHALL begin a new burst (back-to-back), since the state is IDLE in that cycle.
REQ-025 The counter and bit counter SHALL never wrap in RUN; their maxima are bounded by the latched values.
REQ-026 num_bits = 2^CNT_W-1 and div_half = 2^DIV_W-1 SHALL operate correctly without overflow.

Reset
REQ-027 reset=1 at any clock edge, including mid-burst, SHALL force the following values:
- state = IDLE, counters = 0.
- sclk = current cpol input.
- lead_edge = trail_edge = done = busy = 0.
- No done pulse for the aborted burst.
REQ-028 The cycle after reset deasserts SHALL accept start.

Structure
REQ-029 Package spi_pkg SHALL hold the state typedef sclk_state_t (IDLE, RUN) and the default DIV_W/CNT_W localparams.
REQ-030 The divide counter SHALL be a sub-module div_counter (parametrised width, load/clear, terminal-count output); the FSM, edge logic and bit counter live in spi_sclk_gen.

Verification
REQ-031 div_half=9, cpol=0, num_bits=8, start pulse: the bench SHALL check the following.
- 8 SCLK cycles, each high 10 and low 10 clk_in cycles.
- First rise 10 cycles after busy rises.
- 8 lead_edge and 8 trail_edge strobes.
- done coincident with the 8th fall.
REQ-032 cpol=1, div_half=0, num_bits=3: the bench SHALL check that sclk idles high, toggles every cycle (3 falls = lead, 3 rises = trail), and ends high with done.
REQ-033 num_bits=0 with start: the bench SHALL check a single done pulse the next cycle, busy never high, and sclk unchanged.
REQ-034 During a num_bits=8 burst, with div_half changed to 2 and start/cpol toggled: the bench SHALL check that the half-period stays 10 cycles and exactly 8 cycles are produced.
REQ-035 reset asserted after the 3rd lead edge: the bench SHALL check that the next cycle has busy=0, sclk=cpol, all strobes 0, no done, and that a new start then yields a full burst.
REQ-036 start held high across done with num_bits=2: the bench SHALL check that a second burst starts the cycle after done, with no idle gap beyond one cycle.
